// File: rtl/pixel_video_stream_gen.sv
`default_nettype none
// ============================================================================
// Module : pixel_video_stream_gen
// Brief  : AXI4-Lite configured framer turning a pixel beat stream into a
//          video stream with tuser (start of frame) and tlast (end of line).
// Rev    : 1.0  initial release
// ============================================================================
module pixel_video_stream_gen #(
  parameter int PIX_W              = 24,
  parameter int PPC                = 1,
  parameter int DIM_W              = 12,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic [PIX_W*PPC-1:0]              pix_data,
  input  logic                              pix_valid,
  output logic                              pix_ready,
  output logic [PIX_W*PPC-1:0]              m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tuser,
  output logic                              m_axis_tlast
);

  localparam int c_DW = C_S_AXI_DATA_WIDTH;
  localparam int c_AW = C_S_AXI_ADDR_WIDTH;
  localparam logic [c_AW-1:0] c_ADDR_CTRL   = c_AW'(0);
  localparam logic [c_AW-1:0] c_ADDR_HSIZE  = c_AW'(4);
  localparam logic [c_AW-1:0] c_ADDR_VSIZE  = c_AW'(8);
  localparam logic [c_AW-1:0] c_ADDR_STATUS = c_AW'(12);
  localparam logic [DIM_W-1:0] c_PPC_D    = DIM_W'(PPC);
  localparam logic [DIM_W-1:0] c_PPC_MASK = DIM_W'(PPC - 1);
  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_ACTIVE = 2'd1;
  localparam logic [1:0] c_ST_DRAIN  = 2'd2;

  logic             r_awready, r_bvalid, r_arready, r_rvalid;
  logic [c_DW-1:0]  r_rdata, w_rd_val;
  logic             r_en;
  logic [DIM_W-1:0] r_hsize, r_vsize, r_hlat, r_vlat, r_x, r_y;
  logic [1:0]       r_state;
  logic [15:0]      r_frame_cnt;
  logic             r_cfg_err, r_stall;
  logic [3:0]       r_stall_cnt;
  logic [PIX_W*PPC-1:0] r_tdata;
  logic             r_tvalid, r_tuser, r_tlast;
  logic             w_wr_fire, w_rd_fire, w_clr, w_cfg_ok, w_accept;
  logic             w_line_end, w_frame_end;
  logic [DIM_W-1:0] w_x_next;

  function automatic logic [c_DW-1:0] f_merge(input logic [c_DW-1:0] cur,
                                              input logic [c_DW-1:0] wd,
                                              input logic [c_DW/8-1:0] st);
    logic [c_DW-1:0] v;
    v = cur;
    for (int b = 0; b < c_DW/8; b++) begin
      if (st[b]) v[8*b +: 8] = wd[8*b +: 8];
    end
    return v;
  endfunction

  assign w_wr_fire = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
  assign w_rd_fire = r_arready & S_AXI_ARVALID;
  assign w_clr     = w_wr_fire && (S_AXI_AWADDR == c_ADDR_CTRL) && S_AXI_WSTRB[0] && S_AXI_WDATA[1];

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_awready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;

  always_comb begin
    w_rd_val = '0;
    case (S_AXI_ARADDR)
      c_ADDR_CTRL:   w_rd_val[0] = r_en;
      c_ADDR_HSIZE:  w_rd_val = c_DW'(r_hsize);
      c_ADDR_VSIZE:  w_rd_val = c_DW'(r_vsize);
      c_ADDR_STATUS: begin
        w_rd_val[15:0] = r_frame_cnt;
        w_rd_val[16]   = (r_state != c_ST_IDLE);
        w_rd_val[17]   = r_cfg_err;
        w_rd_val[18]   = r_stall;
      end
      default: w_rd_val = '0;
    endcase
  end

  // Register bank; CLR is a pulse decoded from the write, never stored.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_en      <= 1'b0;
      r_hsize   <= '0;
      r_vsize   <= '0;
    end else begin
      r_awready <= !r_awready && !r_bvalid && S_AXI_AWVALID && S_AXI_WVALID;
      if (w_wr_fire) begin
        r_bvalid <= 1'b1;
        case (S_AXI_AWADDR)
          c_ADDR_CTRL:  if (S_AXI_WSTRB[0]) r_en <= S_AXI_WDATA[0];
          c_ADDR_HSIZE: r_hsize <= DIM_W'(f_merge(c_DW'(r_hsize), S_AXI_WDATA, S_AXI_WSTRB));
          c_ADDR_VSIZE: r_vsize <= DIM_W'(f_merge(c_DW'(r_vsize), S_AXI_WDATA, S_AXI_WSTRB));
          default: ;
        endcase
      end else if (S_AXI_BREADY) begin
        r_bvalid <= 1'b0;
      end
      r_arready <= !r_arready && !r_rvalid && S_AXI_ARVALID;
      if (w_rd_fire) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_val;
      end else if (S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign w_cfg_ok    = (r_hsize != '0) && (r_vsize != '0) && ((r_hsize & c_PPC_MASK) == '0);
  assign pix_ready   = (r_state == c_ST_ACTIVE) && (!r_tvalid || m_axis_tready);
  assign w_accept    = pix_valid && pix_ready;
  assign w_x_next    = r_x + c_PPC_D;
  assign w_line_end  = (w_x_next == r_hlat);
  assign w_frame_end = w_line_end && (r_y == r_vlat - DIM_W'(1));

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tlast  = r_tlast;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state     <= c_ST_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_hlat      <= '0;
      r_vlat      <= '0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tuser     <= 1'b0;
      r_tlast     <= 1'b0;
      r_frame_cnt <= '0;
      r_cfg_err   <= 1'b0;
      r_stall     <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_tdata  <= pix_data;
        r_tvalid <= 1'b1;
        r_tuser  <= (r_x == '0) && (r_y == '0);
        r_tlast  <= w_line_end;
      end else if (m_axis_tready) begin
        r_tvalid <= 1'b0;
      end

      // Counter saturates at 15; the 16th stalled edge raises STALL.
      if (r_tvalid && !m_axis_tready) begin
        if (r_stall_cnt == 4'hF) r_stall <= 1'b1;
        else                     r_stall_cnt <= r_stall_cnt + 4'd1;
      end else begin
        r_stall_cnt <= '0;
      end

      case (r_state)
        c_ST_IDLE: begin
          if (r_en) begin
            if (w_cfg_ok) begin
              r_state <= c_ST_ACTIVE;
              r_hlat  <= r_hsize;
              r_vlat  <= r_vsize;
              r_x     <= '0;
              r_y     <= '0;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        c_ST_ACTIVE: begin
          if (w_accept) begin
            if (w_line_end) begin
              r_x <= '0;
              if (w_frame_end) begin
                r_y         <= '0;
                r_frame_cnt <= r_frame_cnt + 16'd1;
                if (r_en && w_cfg_ok) begin
                  r_hlat <= r_hsize;
                  r_vlat <= r_vsize;
                end else begin
                  r_state <= c_ST_DRAIN;
                  if (r_en) r_cfg_err <= 1'b1;
                end
              end else begin
                r_y <= r_y + DIM_W'(1);
              end
            end else begin
              r_x <= w_x_next;
            end
          end
        end
        c_ST_DRAIN: if (!r_tvalid) r_state <= c_ST_IDLE;
        default:    r_state <= c_ST_IDLE;
      endcase

      if (w_clr) begin
        r_frame_cnt <= '0;
        r_cfg_err   <= 1'b0;
        r_stall     <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixel_video_stream_gen.sv
`default_nettype none
// ============================================================================
// Module : tb_pixel_video_stream_gen
// Brief  : Self-checking bench: frame-position model plus register checks.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pixel_video_stream_gen;

  localparam int BPL   = 8;
  localparam int LINES = 2;

  typedef struct packed {
    logic [23:0] d;
    logic        u;
    logic        l;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        axi_sel;
  logic [3:0]  awaddr, araddr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;

  logic        awready1, wready1, bvalid1, arready1, rvalid1;
  logic        awready2, wready2, bvalid2, arready2, rvalid2;
  logic [1:0]  bresp1, rresp1, bresp2, rresp2;
  logic [31:0] rdata1, rdata2;
  logic        awready_m, wready_m, bvalid_m, arready_m, rvalid_m;
  logic [1:0]  bresp_m;
  logic [31:0] rdata_m;

  logic [23:0] pix_data;
  logic        pix_valid, pix_ready;
  logic [23:0] tdata;
  logic        tvalid, tready, tuser, tlast;

  logic [47:0] tdata2;
  logic        pix_ready2, tvalid2, tuser2, tlast2;

  assign awready_m = axi_sel ? awready2 : awready1;
  assign wready_m  = axi_sel ? wready2  : wready1;
  assign bvalid_m  = axi_sel ? bvalid2  : bvalid1;
  assign bresp_m   = axi_sel ? bresp2   : bresp1;
  assign arready_m = axi_sel ? arready2 : arready1;
  assign rvalid_m  = axi_sel ? rvalid2  : rvalid1;
  assign rdata_m   = axi_sel ? rdata2   : rdata1;

  pixel_video_stream_gen u_dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid && !axi_sel), .S_AXI_AWREADY(awready1),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid && !axi_sel), .S_AXI_WREADY(wready1),
    .S_AXI_BRESP(bresp1), .S_AXI_BVALID(bvalid1), .S_AXI_BREADY(bready && !axi_sel),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid && !axi_sel), .S_AXI_ARREADY(arready1),
    .S_AXI_RDATA(rdata1), .S_AXI_RRESP(rresp1), .S_AXI_RVALID(rvalid1), .S_AXI_RREADY(rready && !axi_sel),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tuser(tuser), .m_axis_tlast(tlast)
  );

  pixel_video_stream_gen #(.PPC(2)) u_dut2 (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid && axi_sel), .S_AXI_AWREADY(awready2),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid && axi_sel), .S_AXI_WREADY(wready2),
    .S_AXI_BRESP(bresp2), .S_AXI_BVALID(bvalid2), .S_AXI_BREADY(bready && axi_sel),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid && axi_sel), .S_AXI_ARREADY(arready2),
    .S_AXI_RDATA(rdata2), .S_AXI_RRESP(rresp2), .S_AXI_RVALID(rvalid2), .S_AXI_RREADY(rready && axi_sel),
    .pix_data(48'h0), .pix_valid(1'b0), .pix_ready(pix_ready2),
    .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid2), .m_axis_tready(1'b1),
    .m_axis_tuser(tuser2), .m_axis_tlast(tlast2)
  );

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  int    model_k = 0;
  int    out_cnt = 0;
  logic [15:0] user_mask = '0;
  logic [15:0] last_mask = '0;
  beat_t held;
  bit    held_valid = 0;
  bit    pr2_seen = 0;
  int    tr_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected beat from its position in the frame: tuser on the first beat,
  // tlast on every BPL-th beat.
  function automatic void model_push(input logic [23:0] d);
    beat_t b;
    b.d = d;
    b.u = (model_k == 0);
    b.l = (((model_k + 1) % BPL) == 0);
    exp_q.push_back(b);
    model_k = (model_k + 1) % (BPL * LINES);
  endfunction

  task automatic clear_frame_stats();
    out_cnt = 0;
    user_mask = '0;
    last_mask = '0;
  endtask

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tr_mode)
        0:       tready = 1'b1;
        1:       tready = ~tready;
        default: tready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (pix_ready2 === 1'b1) pr2_seen = 1;
  end

  always @(negedge clk) begin
    beat_t act, e;
    if (rst_n) begin
      act = '{d: tdata, u: tuser, l: tlast};
      if (held_valid) begin
        checks++;
        if (!tvalid || act !== held) begin
          errors++;
          $display("FAIL stall_hold: got v=%b %h expected v=1 %h", tvalid, act, held);
        end
      end
      if (tvalid && tready) begin
        held_valid = 0;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_beat: got %h expected no beat", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            errors++;
            $display("FAIL beat_%0d: got d=%h u=%b l=%b expected d=%h u=%b l=%b",
                     out_cnt, act.d, act.u, act.l, e.d, e.u, e.l);
          end
        end
        if (out_cnt < 16) begin
          user_mask[out_cnt] = tuser;
          last_mask[out_cnt] = tlast;
        end
        out_cnt++;
      end else if (tvalid) begin
        held = act;
        held_valid = 1;
      end else begin
        held_valid = 0;
      end
    end else begin
      held_valid = 0;
    end
  end

  task automatic send(input logic [23:0] d);
    bit ok = 0;
    pix_data  = d;
    pix_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (pix_ready) ok = 1;
    end
    if (ok) begin
      @(posedge clk);
      model_push(d);
      #1;
    end else begin
      checks++;
      errors++;
      $display("FAIL pix_accept_timeout: got ready=0 expected ready=1");
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !tvalid) ok = 1;
    end
    check(name, {31'd0, ok}, 32'd1);
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    bit ok = 0;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (awready_m) begin
        ok = 1;
        check("aw_w_ready_together", {31'd0, wready_m}, 32'd1);
      end
    end
    @(posedge clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0;
    if (!ok) begin
      check("axi_aw_timeout", 32'd0, 32'd1);
      return;
    end
    ok = 0;
    bready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bvalid_m) ok = 1;
    end
    check("axi_b_resp", {30'd0, ok ? bresp_m : 2'b11}, 32'd0);
    @(posedge clk);
    #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    bit ok = 0;
    d = 32'hDEAD_BEEF;
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (arready_m) ok = 1;
    end
    @(posedge clk);
    #1;
    arvalid = 1'b0;
    if (!ok) begin
      check("axi_ar_timeout", 32'd0, 32'd1);
      return;
    end
    ok = 0;
    rready = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rvalid_m) begin
        ok = 1;
        d = rdata_m;
      end
    end
    @(posedge clk);
    #1;
    rready = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] v;
    axi_read(a, v);
    check(name, v, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; axi_sel = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    pix_data = '0; pix_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {24'd0, tvalid, tuser, tlast, pix_ready, awready1, arready1, bvalid1, rvalid1}, 32'd0);
    rst_n = 1'b1;

    // Register bank
    read_check("ctrl_reset", 4'h0, 32'h0);
    axi_write(4'h4, 32'd8, 4'hF);
    axi_write(4'h8, 32'd2, 4'hF);
    read_check("hsize_rd", 4'h4, 32'd8);
    read_check("vsize_rd", 4'h8, 32'd2);
    read_check("status_idle", 4'hC, 32'h0);
    axi_write(4'h4, 32'h0000_0ABC, 4'hF);
    read_check("hsize_full", 4'h4, 32'h0000_0ABC);
    axi_write(4'h4, 32'hFFFF_FF12, 4'b0001);
    read_check("hsize_wstrb", 4'h4, 32'h0000_0A12);
    axi_write(4'h4, 32'hFFFF_F000, 4'hF);
    read_check("hsize_unmapped", 4'h4, 32'h0);
    axi_write(4'hC, 32'hFFFF_FFFF, 4'hF);
    read_check("status_ro", 4'hC, 32'h0);
    axi_write(4'h4, 32'd8, 4'hF);

    // Frame 1: full throughput
    clear_frame_stats();
    axi_write(4'h0, 32'h1, 4'hF);
    for (int i = 0; i < 16; i++) send(24'(32'hA5A5A5 ^ (i * 32'h010203)));
    wait_drain("f1_drain");
    check("f1_beats", out_cnt, 32'd16);
    check("f1_tuser_mask", {16'd0, user_mask}, 32'h0001);
    check("f1_tlast_mask", {16'd0, last_mask}, 32'h8080);
    read_check("f1_status", 4'hC, 32'h0001_0001);

    // Frame 2: tready toggling
    clear_frame_stats();
    tr_mode = 1;
    for (int i = 0; i < 16; i++) send(24'($urandom));
    wait_drain("f2_drain");
    tr_mode = 0;
    check("f2_beats", out_cnt, 32'd16);
    check("f2_tlast_mask", {16'd0, last_mask}, 32'h8080);
    read_check("f2_status", 4'hC, 32'h0001_0002);

    // Frame 3: CLR, EN dropped mid-frame, long stall
    axi_write(4'h0, 32'h3, 4'hF);
    read_check("clr_active", 4'hC, 32'h0001_0000);
    clear_frame_stats();
    for (int i = 0; i < 4; i++) send(24'h300000 + 24'(i));
    axi_write(4'h0, 32'h0, 4'hF);
    tr_mode = 2;
    send(24'h300004);
    repeat (20) @(posedge clk);
    read_check("stall_set", 4'hC, 32'h0005_0000);
    tr_mode = 0;
    for (int i = 5; i < 16; i++) send(24'h300000 + 24'(i));
    wait_drain("f3_drain");
    repeat (3) @(posedge clk);
    check("f3_beats", out_cnt, 32'd16);
    read_check("f3_status_idle", 4'hC, 32'h0004_0001);

    // Illegal configuration on the 2-pixel-per-beat instance
    axi_sel = 1'b1;
    axi_write(4'h4, 32'd5, 4'hF);
    axi_write(4'h8, 32'd2, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    repeat (5) @(posedge clk);
    read_check("cfg_err_set", 4'hC, 32'h0002_0000);
    check("ppc2_pix_ready", {31'd0, pr2_seen}, 32'd0);
    axi_write(4'h0, 32'h2, 4'hF);
    read_check("cfg_err_clr", 4'hC, 32'h0);
    axi_sel = 1'b0;

    // Reset in the middle of a frame
    axi_write(4'h0, 32'h1, 4'hF);
    clear_frame_stats();
    for (int i = 0; i < 6; i++) send(24'h400000 + 24'(i));
    rst_n = 1'b0;
    exp_q.delete();
    model_k = 0;
    #1;
    check("async_reset_outputs", {24'd0, tvalid, tuser, tlast, pix_ready, awready1, arready1, bvalid1, rvalid1}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    axi_write(4'h4, 32'd8, 4'hF);
    axi_write(4'h8, 32'd2, 4'hF);
    axi_write(4'h0, 32'h1, 4'hF);
    read_check("post_reset_status", 4'hC, 32'h0001_0000);
    clear_frame_stats();
    for (int i = 0; i < 8; i++) send(24'h500000 + 24'(i));
    read_check("mid_frame_cnt", 4'hC, 32'h0001_0000);
    for (int i = 8; i < 16; i++) send(24'h500000 + 24'(i));
    wait_drain("f4_drain");
    check("f4_tuser_mask", {16'd0, user_mask}, 32'h0001);
    read_check("f4_status", 4'hC, 32'h0001_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
